fwd_y_buffered: RTL and testbench

- Buffered, parametrised successor to the combinational Y-direction forwarder in the router datapath.
- Accepts packets over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Steers the head packet to the south output when its dy field is non-zero, otherwise to the local output.
- Optionally decrements dy on the south hop; keeps wrapping per-output packet counters for debug.

---
 rtl/router_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fwd_y_buffered.sv | 103 ++++++++++
 tb/tb_fwd_y_buffered.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Packet layout shared by the X- and Y-direction forwarders: default sizes,
// the packet type and helpers to read and rewrite the dy hop-count field.
package router_pkg;

  localparam int PKT_W_DEF  = 16;
  localparam int DY_LSB_DEF = 8;
  localparam int DY_W_DEF   = 4;

  typedef logic [PKT_W_DEF-1:0] packet_t;
  typedef logic [DY_W_DEF-1:0]  dy_t;

  function automatic dy_t get_dy(input packet_t pkt);
    return pkt[DY_LSB_DEF +: DY_W_DEF];
  endfunction

  function automatic packet_t set_dy(input packet_t pkt, input dy_t dy);
    packet_t res;
    res = pkt;
    res[DY_LSB_DEF +: DY_W_DEF] = dy;
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view, so a word pushed into an
// empty FIFO is visible on dout the cycle after the push.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset: clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fwd_y_buffered.sv
// Buffered Y-direction forwarder: queues packets and steers the head south
// while dy is non-zero (optionally decrementing dy), otherwise to local.
module fwd_y_buffered
  import router_pkg::*;
#(
  parameter int PKT_W  = PKT_W_DEF,
  parameter int DY_LSB = DY_LSB_DEF,
  parameter int DY_W   = DY_W_DEF,
  parameter int DEPTH  = 4,
  parameter int DEC_DY = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         packet_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [PKT_W-1:0]         packet_south,
  output logic                     valid_south,
  input  logic                     ready_south,
  output logic [PKT_W-1:0]         packet_local,
  output logic                     valid_local,
  input  logic                     ready_local,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         cnt_south,
  output logic [CNT_W-1:0]         cnt_local
);

  logic [PKT_W-1:0] head;
  logic [PKT_W-1:0] south_rw;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             head_active;
  logic             dy_nz;
  logic [CNT_W-1:0] cnt_south_reg;
  logic [CNT_W-1:0] cnt_local_reg;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (packet_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign ready_in    = !rst && !fifo_full;
  assign push        = valid_in && ready_in;
  assign head_active = !rst && !fifo_empty;
  assign dy_nz       = |head[DY_LSB +: DY_W];
  assign valid_south = head_active && dy_nz;
  assign valid_local = head_active && !dy_nz;
  assign pop         = (valid_south && ready_south) || (valid_local && ready_local);

  // dy-1 cannot underflow: the south path is only selected when dy >= 1.
  generate
    if (DEC_DY != 0) begin : g_dec
      if (PKT_W == PKT_W_DEF && DY_LSB == DY_LSB_DEF && DY_W == DY_W_DEF) begin : g_pkg
        assign south_rw = set_dy(head, get_dy(head) - dy_t'(1));
      end else begin : g_generic
        logic [DY_W-1:0] dy_dec;
        assign dy_dec = head[DY_LSB +: DY_W] - DY_W'(1);
        for (genvar gi = 0; gi < PKT_W; gi++) begin : g_bit
          if (gi >= DY_LSB && gi < DY_LSB + DY_W) begin : g_fld
            assign south_rw[gi] = dy_dec[gi-DY_LSB];
          end else begin : g_pass
            assign south_rw[gi] = head[gi];
          end
        end
      end
    end else begin : g_nodec
      assign south_rw = head;
    end
  endgenerate

  assign packet_south = head_active ? south_rw : '0;
  assign packet_local = head_active ? head : '0;
  assign cnt_south    = cnt_south_reg;
  assign cnt_local    = cnt_local_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_south_reg <= '0;
      cnt_local_reg <= '0;
    end else begin
      if (valid_south && ready_south) begin
        cnt_south_reg <= cnt_south_reg + CNT_W'(1);
      end
      if (valid_local && ready_local) begin
        cnt_local_reg <= cnt_local_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_y_buffered.sv
// Scoreboard bench for fwd_y_buffered: accepted packets are queued in a
// reference model and a negedge monitor checks every delivery against it.
module tb_fwd_y_buffered;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] packet_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [15:0] packet_south;
  logic        valid_south;
  logic        ready_south = 1'b0;
  logic [15:0] packet_local;
  logic        valid_local;
  logic        ready_local = 1'b0;
  logic [2:0]  occupancy;
  logic [15:0] cnt_south;
  logic [15:0] cnt_local;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_q[$];
  logic [15:0] model_cs = '0;
  logic [15:0] model_cl = '0;

  fwd_y_buffered #(
    .PKT_W (16), .DY_LSB (8), .DY_W (4), .DEPTH (DEPTH), .DEC_DY (1), .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .packet_in    (packet_in),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .packet_south (packet_south),
    .valid_south  (valid_south),
    .ready_south  (ready_south),
    .packet_local (packet_local),
    .valid_local  (valid_local),
    .ready_local  (ready_local),
    .occupancy    (occupancy),
    .cnt_south    (cnt_south),
    .cnt_local    (cnt_local)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of accepted packets; south delivery is the
  // packet with one subtracted from its dy nibble (bits 11:8).
  always @(negedge clk) begin : monitor
    logic [15:0] hp;
    chk("ready_in", ready_in, (!rst && model_q.size() < DEPTH));
    chk("occupancy", occupancy, model_q.size());
    chk("cnt_south", cnt_south, model_cs);
    chk("cnt_local", cnt_local, model_cl);
    if (rst) begin
      chk("rst_valid_south", valid_south, 0);
      chk("rst_valid_local", valid_local, 0);
      chk("rst_packet_south", packet_south, 0);
      chk("rst_packet_local", packet_local, 0);
      model_q.delete();
      model_cs = '0;
      model_cl = '0;
    end else begin
      if (model_q.size() == 0) begin
        chk("empty_valid_south", valid_south, 0);
        chk("empty_valid_local", valid_local, 0);
      end else begin
        hp = model_q[0];
        if (hp[11:8] != 4'd0) begin
          chk("head_valid_south", valid_south, 1);
          chk("head_valid_local", valid_local, 0);
          chk("packet_south", packet_south, hp - 16'h0100);
          if (ready_south) begin
            $display("deliver south %04h (from %04h)", packet_south, hp);
            void'(model_q.pop_front());
            model_cs = model_cs + 16'd1;
          end
        end else begin
          chk("head_valid_local", valid_local, 1);
          chk("head_valid_south", valid_south, 0);
          chk("packet_local", packet_local, hp);
          if (ready_local) begin
            $display("deliver local %04h", packet_local);
            void'(model_q.pop_front());
            model_cl = model_cl + 16'd1;
          end
        end
      end
      if (valid_in && model_q.size() < DEPTH + (ready_in ? 1 : 0) && ready_in) begin
        model_q.push_back(packet_in);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [15:0] p);
    int n;
    @(posedge clk); #1;
    valid_in  = 1'b1;
    packet_in = p;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_timeout: ready_in stayed 0 for packet %04h", p);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] dy;
    int n;
    // 1: reset held two cycles
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_in", ready_in, 1);
    chk("t1_occupancy", occupancy, 0);

    // 2: dy=3 goes south with dy decremented
    ready_south = 1'b1;
    push_pkt(16'h0300);
    @(negedge clk);
    chk("t2_valid_south", valid_south, 1);
    chk("t2_packet_south", packet_south, 16'h0200);
    cycles(1);
    @(negedge clk);
    chk("t2_occupancy", occupancy, 0);
    chk("t2_cnt_south", cnt_south, 1);

    // 3: dy=0 goes local
    ready_south = 1'b0;
    ready_local = 1'b1;
    push_pkt(16'h0000);
    @(negedge clk);
    chk("t3_valid_local", valid_local, 1);
    chk("t3_valid_south", valid_south, 0);
    chk("t3_packet_local", packet_local, 16'h0000);
    cycles(1);
    @(negedge clk);
    chk("t3_cnt_local", cnt_local, 1);

    // 4: fill, extra push ignored, then drain south in order
    ready_local = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_pkt(16'h0100 | 16'(i + 1));
    @(posedge clk); #1;
    valid_in  = 1'b1;
    packet_in = 16'h01ff;
    cycles(3);
    @(negedge clk);
    chk("t4_occupancy_full", occupancy, DEPTH);
    chk("t4_ready_in_full", ready_in, 0);
    @(posedge clk); #1;
    valid_in    = 1'b0;
    ready_south = 1'b1;
    cycles(6);
    @(negedge clk);
    chk("t4_cnt_south", cnt_south, 1 + DEPTH);
    chk("t4_occupancy_empty", occupancy, 0);

    // 5: head-of-line blocking
    ready_south = 1'b0;
    ready_local = 1'b1;
    push_pkt(16'h0100);
    push_pkt(16'h0000);
    cycles(2);
    @(negedge clk);
    chk("t5_valid_local_blocked", valid_local, 0);
    chk("t5_valid_south_held", valid_south, 1);
    @(posedge clk); #1;
    ready_south = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_valid_local_after", valid_local, 1);
    cycles(2);

    // 6: steady push/pop at occupancy 2, then reset mid-stream
    ready_south = 1'b0;
    ready_local = 1'b0;
    push_pkt(16'h0000);
    push_pkt(16'h0000);
    @(posedge clk); #1;
    ready_local = 1'b1;
    valid_in    = 1'b1;
    packet_in   = 16'h00a5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_occupancy_steady", occupancy, 2);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("t6_occupancy_after_rst", occupancy, 0);
    chk("t6_valid_south_after_rst", valid_south, 0);
    chk("t6_valid_local_after_rst", valid_local, 0);
    cycles(4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      dy          = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      packet_in   = {4'($urandom), dy, 8'($urandom)};
      valid_in    = ($urandom_range(0, 1) == 1);
      ready_south = ($urandom_range(0, 2) != 0);
      ready_local = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst         = 1'b0;
    valid_in    = 1'b0;
    ready_south = 1'b1;
    ready_local = 1'b1;
    n = 0;
    @(negedge clk);
    while (occupancy != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_occupancy", occupancy, 0);
    chk("drain_model_empty", model_q.size(), 0);
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
